// File: rtl/jtag_tap_sync_controller.sv
// IEEE 1149.1 TAP controller clocked by the system clock. TCK/TMS/TDI arrive already
// synchronized; TCK edges are found by oversampling, and IR plus BYPASS/IDCODE/USER DRs are shifted.
module jtag_tap_sync_controller #(
  parameter int          IR_WIDTH = 4,
  parameter int          DR_WIDTH = 32,
  parameter logic [31:0] IDCODE   = 32'h4A61_8001
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tckSync,
  input  logic                tmsSync,
  input  logic                tdiSync,
  output logic                tdo,
  output logic                tdoEnable,
  output logic [3:0]          tapState,
  output logic [IR_WIDTH-1:0] irValue,
  input  logic [DR_WIDTH-1:0] userCaptureIn,
  output logic [DR_WIDTH-1:0] userDrOut,
  output logic                userUpdate
);

  typedef enum logic [3:0] {
    TLR   = 4'hF, RTI   = 4'hC,
    SELDR = 4'h7, CAPDR = 4'h6, SHDR  = 4'h2, EX1DR = 4'h1,
    PSDR  = 4'h3, EX2DR = 4'h0, UPDR  = 4'h5,
    SELIR = 4'h4, CAPIR = 4'hE, SHIR  = 4'hA, EX1IR = 4'h9,
    PSIR  = 4'hB, EX2IR = 4'h8, UPIR  = 4'hD
  } tap_state_t;

  localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] IR_USER   = IR_WIDTH'(2);

  tap_state_t          state;
  tap_state_t          state_next;
  logic                tckPrev;
  logic                rise;
  logic                fall;
  logic [IR_WIDTH-1:0] irShift;
  logic [DR_WIDTH-1:0] drShift;
  logic [DR_WIDTH-1:0] dr_shifted;
  logic                bypassReg;
  logic                sel_idcode;
  logic                sel_user;

  assign rise       = tckSync & ~tckPrev;
  assign fall       = ~tckSync & tckPrev;
  assign sel_idcode = (irValue == IR_IDCODE);
  assign sel_user   = (irValue == IR_USER);
  assign tapState   = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= TLR;
    end else if (rise) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      TLR:     state_next = tmsSync ? TLR   : RTI;
      RTI:     state_next = tmsSync ? SELDR : RTI;
      SELDR:   state_next = tmsSync ? SELIR : CAPDR;
      CAPDR:   state_next = tmsSync ? EX1DR : SHDR;
      SHDR:    state_next = tmsSync ? EX1DR : SHDR;
      EX1DR:   state_next = tmsSync ? UPDR  : PSDR;
      PSDR:    state_next = tmsSync ? EX2DR : PSDR;
      EX2DR:   state_next = tmsSync ? UPDR  : SHDR;
      UPDR:    state_next = tmsSync ? SELDR : RTI;
      SELIR:   state_next = tmsSync ? TLR   : CAPIR;
      CAPIR:   state_next = tmsSync ? EX1IR : SHIR;
      SHIR:    state_next = tmsSync ? EX1IR : SHIR;
      EX1IR:   state_next = tmsSync ? UPIR  : PSIR;
      PSIR:    state_next = tmsSync ? EX2IR : PSIR;
      EX2IR:   state_next = tmsSync ? UPIR  : SHIR;
      UPIR:    state_next = tmsSync ? SELDR : RTI;
      default: state_next = TLR;
    endcase
  end

  // IDCODE is a 32-bit chain inside the wider register, so TDI enters at bit 31 for it.
  always_comb begin
    dr_shifted = drShift >> 1;
    if (sel_idcode) begin
      dr_shifted[31] = tdiSync;
    end else begin
      dr_shifted[DR_WIDTH-1] = tdiSync;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tckPrev    <= 1'b0;
      irValue    <= IR_IDCODE;
      irShift    <= '0;
      drShift    <= '0;
      bypassReg  <= 1'b0;
      tdo        <= 1'b0;
      tdoEnable  <= 1'b0;
      userDrOut  <= '0;
      userUpdate <= 1'b0;
    end else begin
      tckPrev    <= tckSync;
      userUpdate <= 1'b0;
      if (rise) begin
        case (state)
          TLR:   irValue <= IR_IDCODE;
          CAPIR: irShift <= IR_WIDTH'(1);
          SHIR:  irShift <= {tdiSync, irShift[IR_WIDTH-1:1]};
          CAPDR: begin
            if (sel_idcode)    drShift   <= DR_WIDTH'(IDCODE);
            else if (sel_user) drShift   <= userCaptureIn;
            else               bypassReg <= 1'b0;
          end
          SHDR: begin
            if (sel_idcode || sel_user) drShift   <= dr_shifted;
            else                        bypassReg <= tdiSync;
          end
          default: ;
        endcase
      end
      // Output and update actions happen on TCK fall, using the state entered at the rise.
      if (fall) begin
        tdoEnable <= (state == SHIR) || (state == SHDR);
        case (state)
          SHIR:    tdo <= irShift[0];
          SHDR:    tdo <= (sel_idcode || sel_user) ? drShift[0] : bypassReg;
          default: tdo <= 1'b0;
        endcase
        if (state == UPIR) begin
          irValue <= irShift;
        end
        if ((state == UPDR) && sel_user) begin
          userDrOut  <= drShift;
          userUpdate <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_tap_sync_controller.sv
// Bench for jtag_tap_sync_controller: oversampled TCK with random high/low widths, a
// table-driven TAP model and expected-bit queues for everything shifted out on TDO.
module tb_jtag_tap_sync_controller;

  localparam int          IR_WIDTH = 4;
  localparam int          DR_WIDTH = 32;
  localparam logic [31:0] IDCODE   = 32'h4A61_8001;

  localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SELDR = 4'h7, S_CAPDR = 4'h6,
                         S_SHDR = 4'h2, S_EX1DR = 4'h1, S_PSDR = 4'h3, S_EX2DR = 4'h0,
                         S_UPDR = 4'h5, S_SELIR = 4'h4, S_CAPIR = 4'hE, S_SHIR = 4'hA,
                         S_EX1IR = 4'h9, S_PSIR = 4'hB, S_EX2IR = 4'h8, S_UPIR = 4'hD;

  logic                clock = 1'b0;
  logic                reset;
  logic                tckSync;
  logic                tmsSync;
  logic                tdiSync;
  logic                tdo;
  logic                tdoEnable;
  logic [3:0]          tapState;
  logic [IR_WIDTH-1:0] irValue;
  logic [DR_WIDTH-1:0] userCaptureIn;
  logic [DR_WIDTH-1:0] userDrOut;
  logic                userUpdate;

  jtag_tap_sync_controller #(
    .IR_WIDTH(IR_WIDTH), .DR_WIDTH(DR_WIDTH), .IDCODE(IDCODE)
  ) dut (
    .clock(clock), .reset(reset), .tckSync(tckSync), .tmsSync(tmsSync), .tdiSync(tdiSync),
    .tdo(tdo), .tdoEnable(tdoEnable), .tapState(tapState), .irValue(irValue),
    .userCaptureIn(userCaptureIn), .userDrOut(userDrOut), .userUpdate(userUpdate)
  );

  always #5 clock = ~clock;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_fail   = 0;
  int         upd_cnt  = 0;
  logic [3:0] model_state = S_TLR;
  logic [3:0] nxt0 [16];
  logic [3:0] nxt1 [16];
  logic [0:0] exp_q [$];

  // Each clock that userUpdate is seen high counts once, so a stretched pulse shows up.
  always @(negedge clock) if (userUpdate === 1'b1) upd_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One TCK period. TDO is sampled just before the rise, as a tester would.
  task automatic pulse(input logic tms, input logic tdi, output logic tdo_seen, output logic en_seen);
    tdo_seen = tdo;
    en_seen  = tdoEnable;
    tmsSync  = tms;
    tdiSync  = tdi;
    tckSync  = 1'b1;
    @(negedge clock);
    tmsSync  = ~tms;
    tdiSync  = 1'($urandom);
    repeat ($urandom_range(0, 2)) @(negedge clock);
    tckSync  = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge clock);
    model_state = tms ? nxt1[model_state] : nxt0[model_state];
    check("tap_state", 64'(tapState), 64'(model_state));
  endtask

  task automatic step(input logic tms);
    logic t, e;
    pulse(tms, 1'($urandom), t, e);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tdo"}, 64'(tdo), 64'd0);
    check({tag, "_tdo_en"}, 64'(tdoEnable), 64'd0);
  endtask

  // From RTI: load val into IR and return to RTI; TDO must show the 01 capture pattern.
  task automatic ir_scan(input logic [IR_WIDTH-1:0] val);
    logic t, e;
    logic [0:0] exp_bit;
    for (int i = 0; i < IR_WIDTH; i++) exp_q.push_back((i == 0) ? 1'b1 : 1'b0);
    step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    for (int i = 0; i < IR_WIDTH; i++) begin
      pulse(i == IR_WIDTH - 1, val[i], t, e);
      exp_bit = exp_q.pop_front();
      check("ir_tdo", 64'(t), 64'(exp_bit));
      check("ir_tdo_en", 64'(e), 64'd1);
    end
    step(1'b1);
    check("ir_value", 64'(irValue), 64'(val));
    step(1'b0);
    check_idle_outputs("ir_idle");
  endtask

  // From RTI: n-bit DR scan through UPDATE_DR back to RTI; expected TDO bits come from exp_q.
  task automatic dr_scan(input int n, input logic [63:0] din);
    logic t, e;
    logic [0:0] exp_bit;
    step(1'b1); step(1'b0); step(1'b0);
    for (int i = 0; i < n; i++) begin
      pulse(i == n - 1, din[i], t, e);
      exp_bit = exp_q.pop_front();
      check("dr_tdo", 64'(t), 64'(exp_bit));
      check("dr_tdo_en", 64'(e), 64'd1);
    end
    step(1'b1);
    step(1'b0);
    check_idle_outputs("dr_idle");
  endtask

  task automatic push_word(input int n, input logic [63:0] w);
    for (int i = 0; i < n; i++) exp_q.push_back(w[i]);
  endtask

  initial begin
    logic [63:0]         din;
    logic [31:0]         cap;
    logic [IR_WIDTH-1:0] irv;
    logic [3:0]          s0;
    logic [IR_WIDTH-1:0] ir0;
    logic                t0, e0;
    int                  base;

    nxt0[S_TLR]   = S_RTI;   nxt1[S_TLR]   = S_TLR;
    nxt0[S_RTI]   = S_RTI;   nxt1[S_RTI]   = S_SELDR;
    nxt0[S_SELDR] = S_CAPDR; nxt1[S_SELDR] = S_SELIR;
    nxt0[S_CAPDR] = S_SHDR;  nxt1[S_CAPDR] = S_EX1DR;
    nxt0[S_SHDR]  = S_SHDR;  nxt1[S_SHDR]  = S_EX1DR;
    nxt0[S_EX1DR] = S_PSDR;  nxt1[S_EX1DR] = S_UPDR;
    nxt0[S_PSDR]  = S_PSDR;  nxt1[S_PSDR]  = S_EX2DR;
    nxt0[S_EX2DR] = S_SHDR;  nxt1[S_EX2DR] = S_UPDR;
    nxt0[S_UPDR]  = S_RTI;   nxt1[S_UPDR]  = S_SELDR;
    nxt0[S_SELIR] = S_CAPIR; nxt1[S_SELIR] = S_TLR;
    nxt0[S_CAPIR] = S_SHIR;  nxt1[S_CAPIR] = S_EX1IR;
    nxt0[S_SHIR]  = S_SHIR;  nxt1[S_SHIR]  = S_EX1IR;
    nxt0[S_EX1IR] = S_PSIR;  nxt1[S_EX1IR] = S_UPIR;
    nxt0[S_PSIR]  = S_PSIR;  nxt1[S_PSIR]  = S_EX2IR;
    nxt0[S_EX2IR] = S_SHIR;  nxt1[S_EX2IR] = S_UPIR;
    nxt0[S_UPIR]  = S_RTI;   nxt1[S_UPIR]  = S_SELDR;

    reset = 1'b1; tckSync = 1'b0; tmsSync = 1'b0; tdiSync = 1'b0; userCaptureIn = '0;
    repeat (3) @(negedge clock);
    check("rst_state", 64'(tapState), 64'hF);
    check("rst_ir", 64'(irValue), 64'd1);
    check("rst_user_out", 64'(userDrOut), 64'd0);
    check("rst_user_upd", 64'(userUpdate), 64'd0);
    check_idle_outputs("rst");
    reset = 1'b0;
    @(negedge clock);

    // Five TMS=1 rises from reset stay in TEST_LOGIC_RESET.
    repeat (5) step(1'b1);
    check("tlr_ir", 64'(irValue), 64'd1);
    check_idle_outputs("tlr");

    // IDCODE readout, LSB first; no USER update for a non-USER instruction.
    step(1'b0);
    base = upd_cnt;
    push_word(32, 64'(IDCODE));
    dr_scan(32, {$urandom, $urandom});
    check("idcode_no_upd", 64'(upd_cnt), 64'(base));

    // BYPASS via IR=F; capture pattern of the IR scan checked inside ir_scan.
    ir_scan(4'hF);
    push_word(4, 64'b1010);
    dr_scan(4, 64'b1101);

    // BYPASS via a random non-IDCODE/USER opcode and a random bit string.
    irv = IR_WIDTH'($urandom_range(2, 15));
    if (irv == 4'd2) irv = 4'd0;
    ir_scan(irv);
    din = {$urandom, $urandom};
    push_word(9, {din[62:0], 1'b0});
    dr_scan(9, din);

    // TLR sets IDCODE back into the IR.
    repeat (5) step(1'b1);
    check("tlr_ir_restore", 64'(irValue), 64'd1);
    step(1'b0);

    // USER: directed pattern then random capture/shift values.
    ir_scan(4'd2);
    for (int k = 0; k < 4; k++) begin
      cap = (k == 0) ? 32'hDEADBEEF : $urandom;
      din = (k == 0) ? 64'h12345678 : 64'($urandom);
      userCaptureIn = cap;
      base = upd_cnt;
      push_word(32, 64'(cap));
      dr_scan(32, din);
      check("user_dr_out", 64'(userDrOut), din & 64'hFFFF_FFFF);
      check("user_upd_pulse", 64'(upd_cnt), 64'(base + 1));
    end

    // Reset in the middle of a USER shift discards everything.
    userCaptureIn = $urandom;
    base = upd_cnt;
    step(1'b1); step(1'b0); step(1'b0);
    repeat (10) step(1'b0);
    #2 reset = 1'b1;
    #1;
    model_state = S_TLR;
    check("midrst_state", 64'(tapState), 64'hF);
    check("midrst_ir", 64'(irValue), 64'd1);
    check("midrst_user_out", 64'(userDrOut), 64'd0);
    check("midrst_user_upd", 64'(userUpdate), 64'd0);
    check_idle_outputs("midrst");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check("midrst_no_upd", 64'(upd_cnt), 64'(base));
    check("midrst_user_hold", 64'(userDrOut), 64'd0);

    // Static TCK: TMS/TDI wiggle but nothing moves.
    step(1'b0);
    s0 = tapState; ir0 = irValue; t0 = tdo; e0 = tdoEnable;
    repeat (20) begin
      tmsSync = 1'($urandom);
      tdiSync = 1'($urandom);
      @(negedge clock);
    end
    check("static_state", 64'(tapState), 64'(s0));
    check("static_ir", 64'(irValue), 64'(ir0));
    check("static_tdo", 64'(tdo), 64'(t0));
    check("static_tdo_en", 64'(tdoEnable), 64'(e0));

    // Random TMS walk checked state by state, then TMS=1 recovery to TLR.
    repeat (40) step(1'($urandom));
    repeat (6) step(1'b1);
    check("walk_tlr", 64'(tapState), 64'hF);
    check("walk_ir", 64'(irValue), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
